mc_ctrl: RTL and testbench

- Multi-cycle sequencing controller for the MIPS datapath (IFU, grf, EXT, ALU, DM), replacing the single-cycle decode-only control.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the per-state enables and muxes.
- Adds a ready handshake to DM so data memory may have variable latency.
- Counts retired instructions and flags memory timeouts.

---
 rtl/mc_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller for the MIPS datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, handshakes DM, counts retirements.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             regw,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic [1:0]       ext_op,
    output logic             mem_req,
    output logic             mem_we,
    output logic [CNT_W-1:0] retired,
    output logic             err
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    // Last wait-counter value before a MEM access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wcnt;
    logic [7:0] wnext;
    logic [2:0] nxt;
    logic       retire;
    logic       tmo;

    logic is_r;
    logic c_addu, c_subu, c_ori, c_lui;
    logic c_lw, c_sw, c_beq;
    logic c_j, c_jal, c_jr;
    logic c_exec;

    // Instruction class decode from the instruction register fields.
    always_comb begin
        is_r   = (op == 6'b000000);
        c_addu = is_r && (funct == 6'b100001);
        c_subu = is_r && (funct == 6'b100011);
        c_jr   = is_r && (funct == 6'b001000);
        c_ori  = (op == 6'b001101);
        c_lui  = (op == 6'b001111);
        c_lw   = (op == 6'b100011);
        c_sw   = (op == 6'b101011);
        c_beq  = (op == 6'b000100);
        c_j    = (op == 6'b000010);
        c_jal  = (op == 6'b000011);
        c_exec = c_addu | c_subu | c_ori | c_lui
               | c_lw | c_sw | c_beq;
    end

    // Per-state control outputs, next state and bookkeeping strobes.
    always_comb begin
        nxt     = S_FETCH;
        retire  = 1'b0;
        tmo     = 1'b0;
        wnext   = 8'd0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 2'd0;
        regw    = 1'b0;
        reg_dst = 2'd0;
        wd_sel  = 2'd0;
        alu_src = 1'b0;
        alu_op  = 3'd0;
        ext_op  = 2'd0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (state)
            S_FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
                nxt   = S_DECODE;
            end
            S_DECODE: begin
                if (c_exec) begin
                    nxt = S_EXEC;
                end else begin
                    retire = 1'b1;
                    if (c_j) begin
                        pc_we  = 1'b1;
                        pc_sel = 2'd2;
                    end else if (c_jal) begin
                        pc_we   = 1'b1;
                        pc_sel  = 2'd2;
                        regw    = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                    end else if (c_jr) begin
                        pc_we  = 1'b1;
                        pc_sel = 2'd3;
                    end
                end
            end
            S_EXEC: begin
                if (c_addu || c_subu) begin
                    alu_op = c_subu ? 3'd1 : 3'd0;
                    nxt    = S_WB;
                end else if (c_ori) begin
                    alu_src = 1'b1;
                    alu_op  = 3'd2;
                    nxt     = S_WB;
                end else if (c_lui) begin
                    alu_src = 1'b1;
                    alu_op  = 3'd3;
                    nxt     = S_WB;
                end else if (c_lw || c_sw) begin
                    alu_src = 1'b1;
                    ext_op  = 2'd1;
                    nxt     = S_MEM;
                end else if (c_beq) begin
                    alu_op = 3'd1;
                    ext_op = 2'd1;
                    pc_we  = zero;
                    pc_sel = 2'd1;
                    retire = 1'b1;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                // Address operands stay selected while DM is busy.
                mem_req = 1'b1;
                mem_we  = c_sw;
                alu_src = 1'b1;
                ext_op  = 2'd1;
                if (mem_ready) begin
                    if (c_lw) begin
                        nxt = S_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (wcnt == TO_LAST) begin
                    tmo = 1'b1;
                end else begin
                    nxt   = S_MEM;
                    wnext = wcnt + 8'd1;
                end
            end
            S_WB: begin
                regw   = 1'b1;
                retire = 1'b1;
                if (c_lw) begin
                    wd_sel = 2'd1;
                end else if (c_addu || c_subu) begin
                    reg_dst = 2'd1;
                end
            end
            default: begin
                nxt = S_FETCH;
            end
        endcase
        if (reset) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            regw    = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // State, wait counter, retirement count and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            wcnt    <= 8'd0;
            retired <= '0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            wcnt  <= wnext;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
            if (tmo) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected traces
// built from the instruction semantics, compared every cycle.
module tb_mc_ctrl;

    localparam int TO = 16;

    localparam int K_ADDU = 0;
    localparam int K_SUBU = 1;
    localparam int K_ORI  = 2;
    localparam int K_LUI  = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_J    = 7;
    localparam int K_JAL  = 8;
    localparam int K_JR   = 9;
    localparam int K_NOP  = 10;

    typedef struct packed {
        logic [2:0]  state;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        regw;
        logic [1:0]  reg_dst;
        logic [1:0]  wd_sel;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic [1:0]  ext_op;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] retired;
        logic        err;
    } rec_t;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  state;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        regw;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [1:0]  ext_op;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] retired;
    logic        err;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    rec_t q[$];
    int exp_ret = 0;
    logic exp_err = 1'b0;

    mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .state(state),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .regw(regw), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
        .mem_req(mem_req), .mem_we(mem_we),
        .retired(retired), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare DUT outputs against the expected trace mid-cycle.
    always @(negedge clk) begin
        rec_t e;
        rec_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{state: state, ir_we: ir_we, pc_we: pc_we,
                  pc_sel: pc_sel, regw: regw, reg_dst: reg_dst,
                  wd_sel: wd_sel, alu_src: alu_src,
                  alu_op: alu_op, ext_op: ext_op,
                  mem_req: mem_req, mem_we: mem_we,
                  retired: retired, err: err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace cyc=%0d got %h want %h",
                         ncyc, a, e);
            end
            ncyc++;
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(input rec_t r, input logic rdy);
        mem_ready = rdy;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t base(input logic [2:0] s);
        rec_t r;
        r = '0;
        r.state   = s;
        r.retired = 32'(exp_ret);
        r.err     = exp_err;
        return r;
    endfunction

    // Issue one instruction; waits = MEM cycles before mem_ready.
    task automatic run(input int k, input logic z, input int waits);
        rec_t r;
        logic rdy;
        case (k)
            K_ADDU: begin op = 6'b000000; funct = 6'b100001; end
            K_SUBU: begin op = 6'b000000; funct = 6'b100011; end
            K_ORI:  begin op = 6'b001101; funct = 6'b000000; end
            K_LUI:  begin op = 6'b001111; funct = 6'b000000; end
            K_LW:   begin op = 6'b100011; funct = 6'b000000; end
            K_SW:   begin op = 6'b101011; funct = 6'b000000; end
            K_BEQ:  begin op = 6'b000100; funct = 6'b000000; end
            K_J:    begin op = 6'b000010; funct = 6'b000000; end
            K_JAL:  begin op = 6'b000011; funct = 6'b000000; end
            K_JR:   begin op = 6'b000000; funct = 6'b001000; end
            default: begin op = 6'b111111; funct = 6'b000000; end
        endcase
        zero = z;
        r = base(3'd0);
        r.ir_we = 1'b1;
        r.pc_we = 1'b1;
        step(r, 1'b0);
        r = base(3'd1);
        if (k == K_J) begin
            r.pc_we = 1'b1; r.pc_sel = 2'd2;
        end else if (k == K_JAL) begin
            r.pc_we = 1'b1; r.pc_sel = 2'd2; r.regw = 1'b1;
            r.reg_dst = 2'd2; r.wd_sel = 2'd2;
        end else if (k == K_JR) begin
            r.pc_we = 1'b1; r.pc_sel = 2'd3;
        end
        step(r, 1'b0);
        if (k >= K_J) begin
            exp_ret++;
            return;
        end
        r = base(3'd2);
        case (k)
            K_SUBU: r.alu_op = 3'd1;
            K_ORI:  begin r.alu_src = 1'b1; r.alu_op = 3'd2; end
            K_LUI:  begin r.alu_src = 1'b1; r.alu_op = 3'd3; end
            K_LW, K_SW: begin r.alu_src = 1'b1; r.ext_op = 2'd1; end
            K_BEQ: begin
                r.alu_op = 3'd1; r.ext_op = 2'd1;
                r.pc_we = z; r.pc_sel = 2'd1;
            end
            default: ;
        endcase
        step(r, 1'b0);
        if (k == K_BEQ) begin
            exp_ret++;
            return;
        end
        if (k == K_LW || k == K_SW) begin
            for (int m = 0; m < TO; m++) begin
                rdy = (m == waits);
                r = base(3'd3);
                r.mem_req = 1'b1;
                r.mem_we  = (k == K_SW);
                r.alu_src = 1'b1;
                r.ext_op  = 2'd1;
                step(r, rdy);
                if (rdy) break;
                if (m == TO - 1) begin
                    exp_err = 1'b1;
                    return;
                end
            end
            if (k == K_SW) begin
                exp_ret++;
                return;
            end
        end
        r = base(3'd4);
        r.regw = 1'b1;
        if (k == K_LW) r.wd_sel = 2'd1;
        if (k == K_ADDU || k == K_SUBU) r.reg_dst = 2'd1;
        step(r, 1'b0);
        exp_ret++;
    endtask

    initial begin
        reset = 1'b1;
        op = 6'b000000;
        funct = 6'b100001;
        zero = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ir_we", 32'(ir_we), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        run(K_ADDU, 1'b0, 0);
        chk("ret_after_addu", retired, 32'd1);
        run(K_SUBU, 1'b0, 0);
        run(K_ORI, 1'b0, 0);
        run(K_LUI, 1'b0, 0);
        run(K_LW, 1'b0, 3);
        run(K_SW, 1'b0, 0);
        run(K_LW, 1'b0, TO - 1);
        chk("ret_after_lw_edge", retired, 32'd7);
        chk("err_after_lw_edge", 32'(err), 32'd0);
        run(K_SW, 1'b0, 1000);
        chk("ret_after_tmo", retired, 32'd7);
        chk("err_after_tmo", 32'(err), 32'd1);
        chk("state_after_tmo", 32'(state), 32'd0);
        run(K_BEQ, 1'b1, 0);
        run(K_BEQ, 1'b0, 0);
        run(K_J, 1'b0, 0);
        run(K_JAL, 1'b0, 0);
        run(K_JR, 1'b0, 0);
        run(K_NOP, 1'b0, 0);
        chk("ret_after_nop", retired, 32'd13);

        // sw interrupted by reset during its second MEM cycle
        op = 6'b101011;
        funct = 6'b000000;
        begin
            rec_t r;
            r = base(3'd0); r.ir_we = 1'b1; r.pc_we = 1'b1;
            step(r, 1'b0);
            r = base(3'd1);
            step(r, 1'b0);
            r = base(3'd2); r.alu_src = 1'b1; r.ext_op = 2'd1;
            step(r, 1'b0);
            r = base(3'd3); r.mem_req = 1'b1; r.mem_we = 1'b1;
            r.alu_src = 1'b1; r.ext_op = 2'd1;
            step(r, 1'b0);
        end
        chk("mid_mem_req_before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = 0;
        exp_err = 1'b0;
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_retired", retired, 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);

        run(K_ADDU, 1'b0, 0);
        chk("post_rst_ret_addu", retired, 32'd1);
        run(K_SW, 1'b0, 1000);
        chk("post_rst_err_tmo", 32'(err), 32'd1);
        run(K_LW, 1'b0, 0);
        chk("final_retired", retired, 32'd2);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
